// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit, round-robin
// grant among full buffers, registered single-cycle broadcast onto the CDB.
module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  int_valid,
  input  logic                  mult_valid,
  input  logic                  div_valid,
  input  logic                  ld_valid,
  input  logic [TAG_WIDTH-1:0]  int_tag,
  input  logic [TAG_WIDTH-1:0]  mult_tag,
  input  logic [TAG_WIDTH-1:0]  div_tag,
  input  logic [TAG_WIDTH-1:0]  ld_tag,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic [DATA_WIDTH-1:0] mult_data,
  input  logic [DATA_WIDTH-1:0] div_data,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  int_ready,
  output logic                  mult_ready,
  output logic                  div_ready,
  output logic                  ld_ready,
  output logic                  cdb_valid,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic [1:0]            cdb_src,
  output logic [2:0]            pending
);

  logic [3:0]            w_valid;
  logic [TAG_WIDTH-1:0]  w_inTag  [4];
  logic [DATA_WIDTH-1:0] w_inData [4];
  logic [3:0]            w_ready;
  logic [3:0]            w_grant;
  logic [1:0]            w_win;
  logic [1:0]            w_idx;
  logic                  w_any;
  logic [2:0]            w_pending;

  logic [3:0]            r_full;
  logic [TAG_WIDTH-1:0]  r_tag  [4];
  logic [DATA_WIDTH-1:0] r_data [4];
  logic [1:0]            r_rrPtr;

  assign w_valid     = {ld_valid, div_valid, mult_valid, int_valid};
  assign w_inTag[0]  = int_tag;
  assign w_inTag[1]  = mult_tag;
  assign w_inTag[2]  = div_tag;
  assign w_inTag[3]  = ld_tag;
  assign w_inData[0] = int_data;
  assign w_inData[1] = mult_data;
  assign w_inData[2] = div_data;
  assign w_inData[3] = ld_data;

  // Round-robin search over full flags only, starting at the pointer.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rrPtr + 2'(k);
      if (!w_any && r_full[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (w_any) begin
      w_grant[w_win] = 1'b1;
    end
  end

  // Ready comes from state and grant alone, so a granted buffer refills at once.
  assign w_ready    = ~r_full | w_grant;
  assign int_ready  = w_ready[0];
  assign mult_ready = w_ready[1];
  assign div_ready  = w_ready[2];
  assign ld_ready   = w_ready[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_valid[i] && w_ready[i]) begin
          r_full[i] <= 1'b1;
          r_tag[i]  <= w_inTag[i];
          r_data[i] <= w_inData[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      r_rrPtr   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= w_any;
      if (w_any) begin
        cdb_tag  <= r_tag[w_win];
        cdb_data <= r_data[w_win];
        cdb_src  <= w_win;
        r_rrPtr  <= w_win + 2'd1;
      end
    end
  end

  always_comb begin
    w_pending = {2'b00, r_full[0]} + {2'b00, r_full[1]}
              + {2'b00, r_full[2]} + {2'b00, r_full[3]};
  end

  assign pending = w_pending;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter, checked every cycle against a
// transaction-level model of the four holding buffers and the CDB register.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          tbValid [4];
  logic [TW-1:0] tbTag   [4];
  logic [DW-1:0] tbData  [4];
  logic          int_ready, mult_ready, div_ready, ld_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0]    cdb_src;
  logic [2:0]    pending;

  int checks = 0;
  int errors = 0;

  // Model state: buffer contents, rotating start position, and what the bus shows.
  bit            mFull [4];
  logic [TW-1:0] mTag  [4];
  logic [DW-1:0] mData [4];
  int            mRr;
  bit            mCdbValid;
  logic [TW-1:0] mCdbTag;
  logic [DW-1:0] mCdbData;
  int            mCdbSrc;

  cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .int_valid(tbValid[0]), .mult_valid(tbValid[1]),
    .div_valid(tbValid[2]), .ld_valid(tbValid[3]),
    .int_tag(tbTag[0]), .mult_tag(tbTag[1]), .div_tag(tbTag[2]), .ld_tag(tbTag[3]),
    .int_data(tbData[0]), .mult_data(tbData[1]), .div_data(tbData[2]), .ld_data(tbData[3]),
    .int_ready(int_ready), .mult_ready(mult_ready), .div_ready(div_ready), .ld_ready(ld_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mFull[i] = 0;
      mTag[i]  = '0;
      mData[i] = '0;
    end
    mRr       = 0;
    mCdbValid = 0;
    mCdbTag   = '0;
    mCdbData  = '0;
    mCdbSrc   = 0;
  endtask

  function automatic int modelWinner();
    for (int k = 0; k < 4; k++) begin
      if (mFull[(mRr + k) % 4]) return (mRr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < 4; i++) n += mFull[i] ? 1 : 0;
    return n;
  endfunction

  task automatic checkAll();
    logic [3:0] expReady;
    int w;
    w = modelWinner();
    for (int i = 0; i < 4; i++) expReady[i] = !mFull[i] || (w == i);
    checkOutput("ready", 64'({ld_ready, div_ready, mult_ready, int_ready}), 64'(expReady));
    checkOutput("cdb_valid", 64'(cdb_valid), 64'(mCdbValid));
    checkOutput("cdb_tag", 64'(cdb_tag), 64'(mCdbTag));
    checkOutput("cdb_data", 64'(cdb_data), 64'(mCdbData));
    checkOutput("cdb_src", 64'(cdb_src), 64'(mCdbSrc));
    checkOutput("pending", 64'(pending), 64'(modelCount()));
  endtask

  // Called just after a falling edge: drive, check, advance the model, cross one rising edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [4*TW-1:0] tags,
                               input logic [4*DW-1:0] datas, input logic fl);
    int  w;
    bit  rdy [4];
    flush = fl;
    for (int i = 0; i < 4; i++) begin
      tbValid[i] = v[i];
      tbTag[i]   = tags[i*TW +: TW];
      tbData[i]  = datas[i*DW +: DW];
    end
    #1;
    checkAll();
    w = modelWinner();
    for (int i = 0; i < 4; i++) rdy[i] = !mFull[i] || (w == i);
    if (fl) begin
      mCdbValid = 0;
    end else if (w >= 0) begin
      mCdbValid = 1;
      mCdbTag   = mTag[w];
      mCdbData  = mData[w];
      mCdbSrc   = w;
      mRr       = (w + 1) % 4;
    end else begin
      mCdbValid = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (fl) begin
        mFull[i] = 0;
      end else if (v[i] && rdy[i]) begin
        mFull[i] = 1;
        mTag[i]  = tags[i*TW +: TW];
        mData[i] = datas[i*DW +: DW];
      end else if (w == i) begin
        mFull[i] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(4'b0000, '0, '0, 1'b0);
  endtask

  task automatic randomCycle(input int flushOdds);
    logic [4*TW-1:0] t;
    logic [4*DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      t[i*TW +: TW] = TW'($urandom);
      d[i*DW +: DW] = DW'($urandom);
    end
    applyStimulus(4'($urandom), t, d, ($urandom_range(flushOdds - 1) == 0));
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tbValid[i] = 1'b0;
      tbTag[i]   = '0;
      tbData[i]  = '0;
    end
    modelReset();

    // Valid presented while reset is held must not be captured.
    #2;
    tbValid[0] = 1'b1;
    tbTag[0]   = TW'(9);
    tbData[0]  = DW'(32'h1234);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkAll();
    tbValid[0] = 1'b0;
    reset = 1'b1;

    applyStimulus(4'b0001, {TW'(0), TW'(0), TW'(0), TW'(3)}, {DW'(0), DW'(0), DW'(0), DW'(32'hAA)}, 1'b0);
    idle(3);

    applyStimulus(4'b1111, {TW'(4), TW'(3), TW'(2), TW'(1)},
                  {DW'(32'h44), DW'(32'h33), DW'(32'h22), DW'(32'h11)}, 1'b0);
    idle(5);

    applyStimulus(4'b0011, {TW'(0), TW'(0), TW'(6), TW'(5)}, {DW'(0), DW'(0), DW'(32'h66), DW'(32'h55)}, 1'b0);
    applyStimulus(4'b0101, {TW'(0), TW'(7), TW'(0), TW'(8)}, {DW'(0), DW'(32'h77), DW'(0), DW'(32'h88)}, 1'b0);
    idle(4);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0010, {TW'(0), TW'(0), TW'(k), TW'(0)}, {DW'(0), DW'(0), DW'(32'hB00 + k), DW'(0)}, 1'b0);
    end
    idle(3);

    applyStimulus(4'b1111, {TW'(20), TW'(21), TW'(22), TW'(23)}, {4{DW'(32'hDEAD)}}, 1'b0);
    applyStimulus(4'b0000, '0, '0, 1'b1);
    idle(3);

    // Reset in the middle of a low phase, with a pulse on the bus and two buffers full.
    applyStimulus(4'b0111, {TW'(0), TW'(12), TW'(11), TW'(10)}, {DW'(0), DW'(32'hC2), DW'(32'hC1), DW'(32'hC0)}, 1'b0);
    idle(1);
    checkOutput("pre_reset_valid", 64'(cdb_valid), 64'(1));
    checkOutput("pre_reset_pending", 64'(pending), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset_valid", 64'(cdb_valid), 64'(0));
    checkOutput("async_reset_pending", 64'(pending), 64'(0));
    checkOutput("async_reset_ready", 64'({ld_ready, div_ready, mult_ready, int_ready}), 64'(4'hF));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b1000, {TW'(17), TW'(0), TW'(0), TW'(0)}, {DW'(32'hF00D), DW'(0), DW'(0), DW'(0)}, 1'b0);
    idle(2);

    for (int c = 0; c < 400; c++) randomCycle(20);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
